// File: rtl/i2c_slave.sv
// I2C target: oversampled SCL/SDA, fixed 7-bit address, byte write/read with open-drain SDA pull.
// Optional build macro I2C_SLAVE_GENERAL_CALL_EN also accepts the general-call address (0000000 + W).
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR  = 7'b1110101,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_pull,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ACK_ADDR = 3'd2,
    RX       = 3'd3,
    ACK_RX   = 3'd4,
    TX       = 3'd5,
    WAIT_ACK = 3'd6
  } state_t;

`ifdef I2C_SLAVE_GENERAL_CALL_EN
  localparam logic GC_EN = 1'b1;
`else
  localparam logic GC_EN = 1'b0;
`endif

  function automatic logic addr_match(input logic [6:0] a, input logic rw);
    return (a == SLAVE_ADDR) || (GC_EN && (a == 7'd0) && !rw);
  endfunction

  // Stage p0: synchronisers, reset to the idle-bus level so no false event follows reset
  logic [SYNC_STAGES-1:0] scl_sync_p0;
  logic [SYNC_STAGES-1:0] sda_sync_p0;
  logic                   scl_s;
  logic                   sda_s;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scl_sync_p0 <= '1;
      sda_sync_p0 <= '1;
    end else begin
      scl_sync_p0 <= {scl_sync_p0[SYNC_STAGES-2:0], scl};
      sda_sync_p0 <= {sda_sync_p0[SYNC_STAGES-2:0], sda_in};
    end
  end

  assign scl_s = scl_sync_p0[SYNC_STAGES-1];
  assign sda_s = sda_sync_p0[SYNC_STAGES-1];

  // Stage p1: edge-detect register and bus events
  logic scl_p1;
  logic sda_p1;
  logic scl_rise;
  logic scl_fall;
  logic start_evt;
  logic stop_evt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scl_p1 <= 1'b1;
      sda_p1 <= 1'b1;
    end else begin
      scl_p1 <= scl_s;
      sda_p1 <= sda_s;
    end
  end

  assign scl_rise  = scl_s & ~scl_p1;
  assign scl_fall  = ~scl_s & scl_p1;
  assign start_evt = scl_s & scl_p1 & sda_p1 & ~sda_s;
  assign stop_evt  = scl_s & scl_p1 & ~sda_p1 & sda_s;

  // Stage p2: protocol FSM
  state_t      state_q,    state_d;
  logic [3:0]  bit_cnt_q,  bit_cnt_d;
  logic [6:0]  shift_q,    shift_d;
  logic        rw_q,       rw_d;
  logic        ack_q,      ack_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        pull_q,     pull_d;
  logic [7:0]  rx_data_q,  rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        tx_req_q,   tx_req_d;
  logic        busy_q,     busy_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 7'd0;
      rw_q       <= 1'b0;
      ack_q      <= 1'b0;
      tx_shift_q <= 8'd0;
      pull_q     <= 1'b0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      ack_q      <= ack_d;
      tx_shift_q <= tx_shift_d;
      pull_q     <= pull_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      busy_q     <= busy_d;
    end
  end

  // ack_q marks the second half of a two-fall sequence (ACK slot, or pending MSB after master ACK)
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    ack_d      = ack_q;
    tx_shift_d = tx_shift_q;
    pull_d     = pull_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    busy_d     = busy_q;

    if (start_evt) begin
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      pull_d    = 1'b0;
      ack_d     = 1'b0;
    end else if (stop_evt) begin
      state_d   = IDLE;
      bit_cnt_d = 4'd0;
      pull_d    = 1'b0;
      ack_d     = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shift_d = {shift_q[5:0], sda_s};
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              rw_d      = sda_s;
              if (addr_match(shift_q, sda_s)) begin
                state_d = ACK_ADDR;
                busy_d  = 1'b1;
              end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        ACK_ADDR, ACK_RX: begin
          if (scl_fall) begin
            if (!ack_q) begin
              ack_d  = 1'b1;
              pull_d = 1'b1;
              if (state_q == ACK_ADDR && rw_q) begin
                tx_shift_d = tx_data;
                tx_req_d   = 1'b1;
              end
            end else begin
              ack_d = 1'b0;
              if (state_q == ACK_ADDR && rw_q) begin
                pull_d  = ~tx_shift_q[7];
                state_d = TX;
              end else begin
                pull_d  = 1'b0;
                state_d = RX;
              end
            end
          end
        end

        RX: begin
          if (scl_rise) begin
            shift_d = {shift_q[5:0], sda_s};
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d  = 4'd0;
              rx_data_d  = {shift_q, sda_s};
              rx_valid_d = 1'b1;
              state_d    = ACK_RX;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        // bit_cnt counts rising edges seen by the master; the fall after the 8th releases SDA
        TX: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              bit_cnt_d = 4'd0;
              pull_d    = 1'b0;
              state_d   = WAIT_ACK;
            end else begin
              tx_shift_d = {tx_shift_q[6:0], 1'b0};
              pull_d     = ~tx_shift_q[6];
            end
          end
        end

        WAIT_ACK: begin
          if (scl_rise && !ack_q) begin
            if (!sda_s) begin
              tx_shift_d = tx_data;
              tx_req_d   = 1'b1;
              ack_d      = 1'b1;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end else if (scl_fall && ack_q) begin
            ack_d     = 1'b0;
            bit_cnt_d = 4'd0;
            pull_d    = ~tx_shift_q[7];
            state_d   = TX;
          end
        end

        default: begin
          pull_d = 1'b0;
          ack_d  = 1'b0;
        end
      endcase
    end
  end

  assign sda_pull = pull_q;
  assign tx_req   = tx_req_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign state    = state_q;

endmodule
